mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction fetch path and the MEM-stage data path. It sequences every access through a req/ack memory handshake and discards fetches killed by a taken branch. It generates the freeze for the fetch stage and the stall for the rest of the pipeline. It sits between the fetch/MEM stages and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, instruction/data width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low (0 = reset)
- if_req  in  1  fetch stage requests instruction at if_addr
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  branch taken; kill any pending/in-flight fetch
- if_valid  out  1  one-cycle pulse, if_instr valid
- if_instr  out  DATA_W  fetched instruction
- if_freeze  out  1  hold PC register
- dm_req  in  1  MEM stage requests data access
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_done  out  1  one-cycle pulse, access complete
- dm_rdata  out  DATA_W  load data, valid with dm_done
- dm_stall  out  1  freeze pipeline until data access completes
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completes current request this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY, IF_DROP.
- IDLE grant rules:
  - dm_req only -> DM_BUSY.
  - if_req only, with if_flush=0 -> IF_BUSY.
  - Both requesting: dm_req wins unless last_grant=DM; then IF wins. last_grant is a 1-bit register that prevents IF starvation.
  - if_req with if_flush=1 -> not granted; the stage presents its new PC next cycle.
- On grant: mem_addr, mem_we and mem_wdata are registered from the winner. mem_we=0 for fetches. mem_req=1 from the next cycle.
- IF_BUSY + mem_ack: register mem_rdata into if_instr; if_valid=1 next cycle; -> IDLE.
- IF_BUSY + if_flush (with or without mem_ack): -> IF_DROP, or directly to IDLE if mem_ack is in the same cycle. Result is discarded and if_valid stays 0.
- IF_DROP: keep mem_req until mem_ack, discard data, -> IDLE.
- DM_BUSY + mem_ack: dm_rdata <= mem_rdata (loads; unchanged for stores); dm_done=1 next cycle; -> IDLE.
- if_flush has no effect in DM_BUSY.
- if_freeze = if_req & ~if_valid.
- dm_stall = dm_req & ~dm_done.
- Requesters hold req/addr/data stable until their valid/done pulse.
- mem_req, mem_addr, mem_we and mem_wdata stay constant from assertion through the mem_ack cycle. mem_req drops the cycle after mem_ack.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE, last_grant=IF. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_instr, dm_done, dm_rdata.
- Reset mid-transaction abandons the request. Memory must tolerate mem_req dropping without ack.
- Request sampled in IDLE at cycle N -> mem_req high at N+1.
- mem_ack at cycle M >= N+1 -> valid/done pulse at M+1, state IDLE at M+1.
- The next grant can be decided at M+1, giving mem_req at M+2.
- Zero-wait memory (ack at N+1): 3 cycles per access. Maximum throughput is one access per 2 cycles.
- if_valid and dm_done are exactly one cycle wide and never high in the same cycle.

## Structure
- Shared package:
  - state enum (IDLE, IF_BUSY, DM_BUSY, IF_DROP)
  - grant constants GRANT_IF=0, GRANT_DM=1
  - default ADDR_W/DATA_W
- Single module.
- Address/data select may reuse the existing Mux2 with width parameter ADDR_W/DATA_W. No further sub-module is required.

## Test plan
- Fetch only, zero-wait memory, if_req=1, if_addr=0x10: mem_req at cycle 1, ack cycle 1 -> if_valid at cycle 2 with mem_rdata. if_freeze high cycles 0-1, low at cycle 2.
- Load with 3-cycle memory delay, dm_addr=0x40: mem_we=0, ack at cycle 4 -> dm_done at cycle 5 with data. dm_stall high cycles 0-4.
- if_req and dm_req both requesting continuously: grants alternate DM, IF, DM, IF. No requester waits more than one foreign transaction.
- if_flush at cycle 2 of a fetch, ack at cycle 4: state goes to IF_DROP, no if_valid, mem_req drops at cycle 5. The new if_addr is granted at cycle 5 with mem_req at cycle 6.
- if_flush coincident with mem_ack in IF_BUSY: if_valid stays 0 and the state returns to IDLE next cycle.
- Store with dm_wdata=0xDEADBEEF: mem_we=1 and mem_wdata stable until ack. Assert rst=0 mid-DM_BUSY -> all outputs 0 next cycle and no dm_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types and constants for the unified-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Encoding of the last_grant register
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        IF_DROP = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            the MEM-stage data path, with fetch kill on taken branch and
//            freeze/stall generation for the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_instr_o,
    output logic              if_freeze_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_done_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              if_valid_q,   if_valid_d;
    logic [DATA_W-1:0] if_instr_q,   if_instr_d;
    logic              dm_done_q,    dm_done_d;
    logic [DATA_W-1:0] dm_rdata_q,   dm_rdata_d;

    // A requester whose pulse is showing this cycle has already been served;
    // masking it prevents a second grant of the same request.
    logic w_if_cand;
    logic w_dm_cand;
    logic w_grant_dm;
    logic w_grant_if;

    assign w_if_cand  = if_req_i & ~if_valid_q & ~if_flush_i;
    assign w_dm_cand  = dm_req_i & ~dm_done_q;
    // Data wins a tie unless it won the previous grant (keeps fetch alive)
    assign w_grant_dm = w_dm_cand & (~w_if_cand | (last_grant_q == GRANT_IF));
    assign w_grant_if = w_if_cand & ~w_grant_dm;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            dm_done_q    <= 1'b0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            dm_done_q    <= dm_done_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Next-state, grant and memory handshake sequencing
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_valid_d   = 1'b0;
        if_instr_d   = if_instr_q;
        dm_done_d    = 1'b0;
        dm_rdata_d   = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (w_grant_dm) begin
                    state_d      = DM_BUSY;
                    last_grant_d = GRANT_DM;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we_i;
                    mem_addr_d   = dm_addr_i;
                    mem_wdata_d  = dm_wdata_i;
                end else if (w_grant_if) begin
                    state_d      = IF_BUSY;
                    last_grant_d = GRANT_IF;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr_i;
                    mem_wdata_d  = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!if_flush_i) begin
                        if_valid_d = 1'b1;
                        if_instr_d = mem_rdata_i;
                    end
                end else if (if_flush_i) begin
                    // The access cannot be withdrawn; finish it and discard
                    state_d = IF_DROP;
                end
            end
            DM_BUSY: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    dm_done_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end
            end
            IF_DROP: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_valid_o  = if_valid_q;
    assign if_instr_o  = if_instr_q;
    assign dm_done_o   = dm_done_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_freeze_o = if_req_i & ~if_valid_q;
    assign dm_stall_o  = dm_req_i & ~dm_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios
//            followed by randomized fetch/load/store traffic against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_valid_o, if_freeze_o;
    logic [31:0] if_addr, if_instr_o;
    logic        dm_req, dm_we, dm_done_o, dm_stall_o;
    logic [31:0] dm_addr, dm_wdata, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_freeze_o(if_freeze_o),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Memory responder state
    int  ack_delay = 0;
    int  age       = 0;
    bit  rand_lat  = 1'b0;
    logic [31:0] mem_arr [logic [31:0]];

    // Reference model state (random phase)
    logic [31:0] ref_mem [logic [31:0]];
    bit          if_pend, dm_pend, last_dm, owner_dm, exp_dm, served;
    bit          p_if_elig, p_dm_elig, p_mem_req, p_mem_ack, p_we, p_dm_we;
    logic [31:0] p_addr, p_wdata, p_if_addr, p_dm_addr, p_dm_wdata, exp_data;
    int          if_wait, dm_wait, n_own;
    bit          own_q [$];
    bit          prev_req;

    // Contents of a never-written memory word
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : pat(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; then act as the memory for the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (!mem_req_o) begin
            age     = 0;
            mem_ack = 1'b0;
        end else begin
            if (age == 0 && rand_lat) ack_delay = $urandom_range(0, 3);
            mem_ack   = (age == ack_delay);
            mem_rdata = mem_ack ? rd(mem_addr_o) : $urandom;
            if (mem_ack && mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
            age++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; if_req = 0; if_flush = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        tick(); tick();
        // ---- reset state
        chk("rst_mem_req", mem_req_o, 0);   chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0); chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_valid", if_valid_o, 0); chk("rst_if_instr", if_instr_o, 0);
        chk("rst_dm_done", dm_done_o, 0);   chk("rst_dm_rdata", dm_rdata_o, 0);
        rst = 1'b1;

        // ---- fetch, zero-wait memory
        ack_delay = 0; if_req = 1; if_addr = 32'h10; #1;
        chk("f0_freeze_c0", if_freeze_o, 1);
        tick();
        chk("f0_req_c1", mem_req_o, 1); chk("f0_addr_c1", mem_addr_o, 32'h10);
        chk("f0_we_c1", mem_we_o, 0);   chk("f0_freeze_c1", if_freeze_o, 1);
        chk("f0_valid_c1", if_valid_o, 0);
        tick();
        chk("f0_valid_c2", if_valid_o, 1); chk("f0_instr_c2", if_instr_o, pat(32'h10));
        chk("f0_freeze_c2", if_freeze_o, 0); chk("f0_req_c2", mem_req_o, 0);
        if_req = 0;
        tick();
        chk("f0_valid_c3", if_valid_o, 0);

        // ---- load with 3-cycle memory delay
        ack_delay = 3; dm_req = 1; dm_we = 0; dm_addr = 32'h40; #1;
        chk("ld_stall_c0", dm_stall_o, 1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("ld_req_c%0d", c), mem_req_o, 1);
            chk($sformatf("ld_we_c%0d", c), mem_we_o, 0);
            chk($sformatf("ld_addr_c%0d", c), mem_addr_o, 32'h40);
            chk($sformatf("ld_stall_c%0d", c), dm_stall_o, 1);
            chk($sformatf("ld_done_c%0d", c), dm_done_o, 0);
        end
        tick();
        chk("ld_done_c5", dm_done_o, 1); chk("ld_rdata_c5", dm_rdata_o, pat(32'h40));
        chk("ld_stall_c5", dm_stall_o, 0);
        dm_req = 0;
        tick();
        chk("ld_done_c6", dm_done_o, 0);

        // ---- both requesting continuously from reset: DM, IF, DM, IF
        rst = 1'b0; tick(); rst = 1'b1;
        ack_delay = 0; if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        prev_req = 0; own_q.delete();
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("arb_pulses_c%0d", c), {31'd0, if_valid_o & dm_done_o}, 0);
            if (mem_req_o && !prev_req) own_q.push_back(mem_addr_o == 32'h40);
            prev_req = mem_req_o;
        end
        n_own = own_q.size();
        chk("arb_grant_count", {31'd0, n_own >= 4}, 1);
        if (n_own >= 4) begin
            chk("arb_grant0_dm", {31'd0, own_q[0]}, 1);
            chk("arb_grant1_if", {31'd0, own_q[1]}, 0);
            chk("arb_grant2_dm", {31'd0, own_q[2]}, 1);
            chk("arb_grant3_if", {31'd0, own_q[3]}, 0);
        end
        if_req = 0; dm_req = 0;
        repeat (4) tick();

        // ---- flush during a fetch, ack arriving later
        if_req = 1; if_addr = 32'h100; ack_delay = 3;
        tick();  // c1
        chk("fl_req_c1", mem_req_o, 1); chk("fl_addr_c1", mem_addr_o, 32'h100);
        tick();  // c2
        if_flush = 1;
        tick();  // c3
        if_flush = 0; if_addr = 32'h200;
        chk("fl_req_c3", mem_req_o, 1); chk("fl_addr_c3", mem_addr_o, 32'h100);
        chk("fl_valid_c3", if_valid_o, 0);
        tick();  // c4 (ack)
        chk("fl_req_c4", mem_req_o, 1); chk("fl_valid_c4", if_valid_o, 0);
        tick();  // c5
        chk("fl_req_c5", mem_req_o, 0); chk("fl_valid_c5", if_valid_o, 0);
        ack_delay = 0;
        tick();  // c6
        chk("fl_req_c6", mem_req_o, 1); chk("fl_addr_c6", mem_addr_o, 32'h200);
        chk("fl_valid_c6", if_valid_o, 0);
        tick();  // c7
        chk("fl_valid_c7", if_valid_o, 1); chk("fl_instr_c7", if_instr_o, pat(32'h200));
        if_req = 0;
        tick();

        // ---- flush coincident with ack
        if_req = 1; if_addr = 32'h300; ack_delay = 1;
        tick();  // c1
        chk("fa_req_c1", mem_req_o, 1);
        tick();  // c2 (ack)
        if_flush = 1;
        tick();  // c3
        chk("fa_valid_c3", if_valid_o, 0); chk("fa_req_c3", mem_req_o, 0);
        if_flush = 0; if_addr = 32'h400;
        tick();  // c4: IDLE at c3 granted the new PC
        chk("fa_req_c4", mem_req_o, 1); chk("fa_addr_c4", mem_addr_o, 32'h400);
        chk("fa_valid_c4", if_valid_o, 0);
        tick();  // c5 (ack)
        tick();  // c6
        chk("fa_valid_c6", if_valid_o, 1); chk("fa_instr_c6", if_instr_o, pat(32'h400));
        if_req = 0;
        tick();

        // ---- store, then reset in the middle of a second store
        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF; ack_delay = 2;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("st_req_c%0d", c), mem_req_o, 1);
            chk($sformatf("st_we_c%0d", c), mem_we_o, 1);
            chk($sformatf("st_addr_c%0d", c), mem_addr_o, 32'h80);
            chk($sformatf("st_wdata_c%0d", c), mem_wdata_o, 32'hDEADBEEF);
            chk($sformatf("st_done_c%0d", c), dm_done_o, 0);
        end
        tick();
        chk("st_done_c4", dm_done_o, 1);
        chk("st_rdata_kept", dm_rdata_o, pat(32'h40));
        dm_req = 0;
        tick();
        chk("st_mem_written", rd(32'h80), 32'hDEADBEEF);
        dm_req = 1; dm_we = 1; dm_addr = 32'h84; dm_wdata = 32'h12345678; ack_delay = 5;
        tick();  // c1
        chk("rs_req_c1", mem_req_o, 1);
        tick();  // c2
        rst = 1'b0;
        tick();  // c3
        chk("rs_mem_req", mem_req_o, 0);   chk("rs_mem_we", mem_we_o, 0);
        chk("rs_mem_addr", mem_addr_o, 0); chk("rs_mem_wdata", mem_wdata_o, 0);
        chk("rs_if_valid", if_valid_o, 0); chk("rs_if_instr", if_instr_o, 0);
        chk("rs_dm_done", dm_done_o, 0);   chk("rs_dm_rdata", dm_rdata_o, 0);
        dm_req = 0; rst = 1'b1;
        tick();
        chk("rs_done_c4", dm_done_o, 0); chk("rs_req_c4", mem_req_o, 0);
        tick();
        chk("rs_done_c5", dm_done_o, 0);
        chk("rs_no_write", {31'd0, mem_arr.exists(32'h84)}, 0);

        // ---- randomized traffic against the reference model
        rst = 1'b0; tick(); rst = 1'b1;
        rand_lat = 1'b1;
        if_pend = 0; dm_pend = 0; last_dm = 0; if_wait = 0; dm_wait = 0;
        p_if_elig = 0; p_dm_elig = 0; p_mem_req = 0; p_mem_ack = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            // grant order and granted request contents
            if (mem_req_o && !p_mem_req) begin
                owner_dm = mem_addr_o[15];
                exp_dm   = p_dm_elig && (!p_if_elig || !last_dm);
                if (!p_if_elig && !p_dm_elig) chk("rnd_spurious_grant", 1, 0);
                else chk("rnd_owner", {31'd0, owner_dm}, {31'd0, exp_dm});
                if (owner_dm) begin
                    chk("rnd_dm_addr", mem_addr_o, p_dm_addr);
                    chk("rnd_dm_we", mem_we_o, p_dm_we);
                    if (p_dm_we) chk("rnd_dm_wdata", mem_wdata_o, p_dm_wdata);
                end else begin
                    chk("rnd_if_addr", mem_addr_o, p_if_addr);
                    chk("rnd_if_we", mem_we_o, 0);
                end
                last_dm = owner_dm;
            end
            // memory bus holds until ack, drops right after
            if (p_mem_req && !p_mem_ack) begin
                chk("rnd_hold_req", mem_req_o, 1);
                chk("rnd_hold_addr", mem_addr_o, p_addr);
                chk("rnd_hold_we", mem_we_o, p_we);
                chk("rnd_hold_wdata", mem_wdata_o, p_wdata);
            end
            if (p_mem_ack) chk("rnd_drop_req", mem_req_o, 0);
            chk("rnd_pulse_overlap", {31'd0, if_valid_o & dm_done_o}, 0);
            served = 0;
            if (if_valid_o) begin
                if (!if_pend) chk("rnd_if_unexpected_valid", 1, 0);
                else chk("rnd_if_instr", if_instr_o, pat(if_addr));
                if_pend = 0; if_req = 0; if_wait = 0; served = 1;
            end
            if (dm_done_o) begin
                if (!dm_pend) chk("rnd_dm_unexpected_done", 1, 0);
                else if (!dm_we) begin
                    exp_data = ref_rd(dm_addr);
                    chk("rnd_dm_rdata", dm_rdata_o, exp_data);
                end else ref_mem[dm_addr] = dm_wdata;
                dm_pend = 0; dm_req = 0; dm_wait = 0; served = 1;
            end
            // requester behaviour
            if (if_flush) begin
                if_flush = 0;
                if_addr  = if_addr + 32'h4 + ({$urandom_range(0, 63)} << 2);
                if_addr  = 32'h1000 | (if_addr & 32'h3FC);
                if_wait  = 0;
            end else if (if_pend && !if_valid_o && ($urandom_range(0, 9) == 0)) begin
                if_flush = 1;
            end
            if (!served && !if_pend && ($urandom_range(0, 2) == 0)) begin
                if_pend = 1; if_req = 1;
                if_addr = 32'h1000 + ({$urandom_range(0, 255)} << 2);
            end
            if (!served && !dm_pend && ($urandom_range(0, 2) == 0)) begin
                dm_pend  = 1; dm_req = 1; dm_we = $urandom_range(0, 1);
                dm_addr  = 32'h8000 + ({$urandom_range(0, 7)} << 2);
                dm_wdata = $urandom;
            end
            if (if_pend) if_wait++;
            if (dm_pend) dm_wait++;
            #1;
            chk("rnd_freeze", if_freeze_o, if_req);
            chk("rnd_stall", dm_stall_o, dm_req);
            if (if_wait > 40 || dm_wait > 40) begin
                chk("rnd_request_timeout", 1, 0);
                break;
            end
            p_if_elig = if_req && !if_flush; p_dm_elig = dm_req;
            p_if_addr = if_addr; p_dm_addr = dm_addr; p_dm_we = dm_we; p_dm_wdata = dm_wdata;
            p_mem_req = mem_req_o; p_mem_ack = mem_ack;
            p_addr = mem_addr_o; p_we = mem_we_o; p_wdata = mem_wdata_o;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
